// File: rtl/imm_decode_stage.sv
// Registered immediate/format decode stage with a 2-entry skid buffer between fetch and execute.
// Each accepted instruction is decoded once into the main or skid register; outputs come from main.
module imm_decode_stage #(
    parameter int XLEN     = 32,
    parameter bit RST_DATA = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    localparam bit RV64 = (XLEN == 64);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
        FMT_U = 3'd4, FMT_J = 3'd5, FMT_CSR = 3'd6
    } fmt_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        fmt_t            fmt;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    function automatic entry_t decode(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        entry_t     e;
        logic [31:0] imm32;
        logic        rel;
        e.instr   = instr;
        e.pc      = pc;
        e.fmt     = FMT_NONE;
        e.illegal = 1'b0;
        imm32     = '0;
        rel       = 1'b0;
        if (instr[1:0] != 2'b11) begin
            e.illegal = 1'b1;
        end else begin
            case (instr[6:2])
                5'b01101: begin e.fmt = FMT_U; imm32 = {instr[31:12], 12'b0}; end
                5'b00101: begin e.fmt = FMT_U; imm32 = {instr[31:12], 12'b0}; rel = 1'b1; end
                5'b11011: begin
                    e.fmt = FMT_J;
                    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                    rel   = 1'b1;
                end
                5'b11001, 5'b00000, 5'b00100: begin
                    e.fmt = FMT_I; imm32 = {{20{instr[31]}}, instr[31:20]};
                end
                5'b00110: begin
                    if (RV64) begin e.fmt = FMT_I; imm32 = {{20{instr[31]}}, instr[31:20]}; end
                    else      e.illegal = 1'b1;
                end
                5'b11000: begin
                    e.fmt = FMT_B;
                    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                    rel   = 1'b1;
                end
                5'b01000: begin e.fmt = FMT_S; imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]}; end
                5'b11100: begin e.fmt = FMT_CSR; imm32 = {27'b0, instr[19:15]}; end
                5'b01100, 5'b00011: ;
                5'b01110: if (!RV64) e.illegal = 1'b1;
                default:  e.illegal = 1'b1;
            endcase
        end
        // The CSR immediate has bit 31 clear, so one sign-extension covers every format.
        e.imm    = XLEN'($signed(imm32));
        e.target = rel ? pc + e.imm : '0;
        return e;
    endfunction

    state_t state, state_nxt;
    entry_t main_q, skid_q, in_dec;
    logic   accept, drain, load_main, load_skid, main_from_skid;

    assign in_dec    = decode(in_instr, in_pc);
    assign out_valid = (state != EMPTY);
    assign in_ready  = rst_n && (state != FULL);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: if (accept) begin state_nxt = ONE; load_main = 1'b1; end
            ONE: begin
                if (accept && drain)  load_main = 1'b1;
                else if (accept)      begin state_nxt = FULL; load_skid = 1'b1; end
                else if (drain)       state_nxt = EMPTY;
            end
            FULL: if (drain) begin state_nxt = ONE; load_main = 1'b1; main_from_skid = 1'b1; end
            default: state_nxt = EMPTY;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) state <= EMPTY;
        else                 state <= state_nxt;
    end

    // NOTE: payload clearing on reset is optional; without it the payload flops need no reset net.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if (RST_DATA) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            if (load_main) main_q <= main_from_skid ? skid_q : in_dec;
            if (load_skid) skid_q <= in_dec;
        end
    end

    assign out_instr   = main_q.instr;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_target  = main_q.target;
    assign out_illegal = main_q.illegal;

endmodule
